// File: rtl/sr_fetch_pkg.sv
// Shared types for the fetch stage.
// Entry bundle, FSM states and the NOP encoding.
package sr_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sr_fetch_fifo.sv
// Fetch buffer: DEPTH fetch_entry_t slots.
// Ports: push/pop/flush/pushData in; full/empty/head out.
module sr_fetch_fifo
  import sr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t pushData,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [AW-1:0] AONE = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;

  assign full  = (count == CDEPTH);
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: 32'h0, instr: RV_NOP};
      end
    end else if (!flush && push) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Flush drops everything, including a pop that
  // would have retired a wrong-path head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AONE;
      if (pop)  rdPtr <= rdPtr + AONE;
      unique case ({push, pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns pc, buffers {pc,instr}.
// Ports: imAddr/imData memory, redirect, outVld/outRdy handshake.
module fetch_stage
  import sr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] imAddr,
  input  logic [31:0] imData,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        outVld,
  input  logic        outRdy,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  fetch_state_t state;
  fetch_state_t nextState;
  logic         running;
  logic [31:0]  pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t newEntry;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_BOOT;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_BOOT: nextState = ST_RUN;
      ST_RUN:  nextState = ST_RUN;
      default: nextState = ST_BOOT;
    endcase
  end

  always_comb begin
    running = 1'b0;
    unique case (state)
      ST_RUN:  running = 1'b1;
      default: running = 1'b0;
    endcase
  end

  assign imAddr = pc >> 2;
  assign outVld = ~empty;
  assign pop    = outVld & outRdy;
  assign push   = running & en & ~redirect
                & (~full | pop);

  assign newEntry = '{pc: pc, instr: imData};

  always_ff @(posedge clk) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= redirectPc & ~32'h3;
    else if (push)     pc <= pc + 32'd4;
  end

  sr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .pushData (newEntry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign instr  = head.instr;
  assign pc_out = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Memory model returns the word address as data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        outVld;
  logic        outRdy;
  logic [31:0] instr;
  logic [31:0] pc_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign imData = imAddr;

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .imAddr     (imAddr),
    .imData     (imData),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .outVld     (outVld),
    .outRdy     (outRdy),
    .instr      (instr),
    .pc_out     (pc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then one BOOT cycle; leaves the bench in
  // the cycle where the first push edge is next.
  task automatic doReset();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    en = 1'b1;
    outRdy = 1'b1;
    redirectPc = 32'h0;
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    vecs++;
    if (outVld !== 1'b0 || instr !== 32'h13 || pc_out !== 32'h0) begin
      errs++;
      $display("FAIL reset_outs vld=%b instr=%h pc=%h want 0/13/0",
               outVld, instr, pc_out);
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (outVld !== 1'b0 || imAddr !== 32'h0) begin
      errs++;
      $display("FAIL boot_cycle vld=%b addr=%h want 0/0", outVld, imAddr);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (outVld !== 1'b1 || pc_out !== 32'(4 * i) || instr !== 32'(i)) begin
        errs++;
        $display("FAIL stream[%0d] vld=%b pc=%h instr=%h want 1/%h/%h",
                 i, outVld, pc_out, instr, 4 * i, i);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    outRdy = 1'b1;
    doReset();
    tick();
    outRdy = 1'b0;
    tick();
    tick();
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h0 || imAddr !== 32'h2) begin
      errs++;
      $display("FAIL stall_hold vld=%b pc=%h addr=%h want 1/0/2",
               outVld, pc_out, imAddr);
    end
    outRdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (outVld !== 1'b1 || pc_out !== 32'(4 * k) || instr !== 32'(k)) begin
        errs++;
        $display("FAIL stall_release[%0d] vld=%b pc=%h instr=%h want 1/%h/%h",
                 k, outVld, pc_out, instr, 4 * k, k);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    outRdy = 1'b1;
    doReset();
    tick();
    outRdy = 1'b0;
    tick();
    tick();
    redirect = 1'b1;
    redirectPc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    vecs++;
    if (outVld !== 1'b0 || imAddr !== 32'h40) begin
      errs++;
      $display("FAIL redir_flush vld=%b addr=%h want 0/40", outVld, imAddr);
    end
    outRdy = 1'b1;
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h100 || instr !== 32'h40) begin
      errs++;
      $display("FAIL redir_target vld=%b pc=%h instr=%h want 1/100/40",
               outVld, pc_out, instr);
    end
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h104 || instr !== 32'h41) begin
      errs++;
      $display("FAIL redir_next vld=%b pc=%h instr=%h want 1/104/41",
               outVld, pc_out, instr);
    end
  endtask

  task automatic test_full_stream();
    outRdy = 1'b1;
    doReset();
    tick();
    outRdy = 1'b0;
    tick();
    outRdy = 1'b1;
    // Buffer holds two entries; pc stays two ahead of head.
    for (int k = 0; k < 6; k++) begin
      vecs++;
      if (outVld !== 1'b1 || pc_out !== 32'(4 * k)
          || imAddr !== 32'(k + 2)) begin
        errs++;
        $display("FAIL full_stream[%0d] vld=%b pc=%h addr=%h want 1/%h/%h",
                 k, outVld, pc_out, imAddr, 4 * k, k + 2);
      end
      tick();
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] popped;
    outRdy = 1'b1;
    doReset();
    tick();
    tick();
    popped = pc_out;
    redirect = 1'b1;
    redirectPc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    vecs++;
    if (outVld !== 1'b0) begin
      errs++;
      $display("FAIL rpop_flush vld=%b want 0", outVld);
    end
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h200 || instr !== 32'h80
        || pc_out === popped) begin
      errs++;
      $display("FAIL rpop_target vld=%b pc=%h instr=%h want 1/200/80",
               outVld, pc_out, instr);
    end
  endtask

  task automatic test_rst_redirect();
    outRdy = 1'b1;
    doReset();
    tick();
    tick();
    tick();
    rst = 1'b1;
    redirect = 1'b1;
    redirectPc = 32'h0000_0300;
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    vecs++;
    if (outVld !== 1'b0 || imAddr !== 32'h0) begin
      errs++;
      $display("FAIL rst_beats_redir vld=%b addr=%h want 0/0", outVld, imAddr);
    end
    tick();
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h0) begin
      errs++;
      $display("FAIL rst_restart vld=%b pc=%h instr=%h want 1/0/0",
               outVld, pc_out, instr);
    end
  endtask

  task automatic test_enable();
    outRdy = 1'b1;
    en = 1'b1;
    doReset();
    tick();
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    vecs++;
    if (outVld !== 1'b0 || imAddr !== 32'h4) begin
      errs++;
      $display("FAIL en_drain vld=%b addr=%h want 0/4", outVld, imAddr);
    end
    tick();
    vecs++;
    if (outVld !== 1'b0 || imAddr !== 32'h4) begin
      errs++;
      $display("FAIL en_freeze vld=%b addr=%h want 0/4", outVld, imAddr);
    end
    en = 1'b1;
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h10 || instr !== 32'h4) begin
      errs++;
      $display("FAIL en_resume vld=%b pc=%h instr=%h want 1/10/4",
               outVld, pc_out, instr);
    end
  endtask

  task automatic test_wrap();
    outRdy = 1'b1;
    doReset();
    tick();
    redirect = 1'b1;
    redirectPc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    vecs++;
    if (outVld !== 1'b0 || imAddr !== 32'h3FFF_FFFF) begin
      errs++;
      $display("FAIL wrap_addr vld=%b addr=%h want 0/3fffffff", outVld, imAddr);
    end
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'hFFFF_FFFC
        || instr !== 32'h3FFF_FFFF || imAddr !== 32'h0) begin
      errs++;
      $display("FAIL wrap_last vld=%b pc=%h instr=%h addr=%h want 1/fffffffc/3fffffff/0",
               outVld, pc_out, instr, imAddr);
    end
    tick();
    vecs++;
    if (outVld !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h0) begin
      errs++;
      $display("FAIL wrap_zero vld=%b pc=%h instr=%h want 1/0/0",
               outVld, pc_out, instr);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    redirect = 1'b0;
    redirectPc = 32'h0;
    outRdy = 1'b1;
    test_reset();
    test_stall();
    test_redirect_full();
    test_full_stream();
    test_redirect_pop();
    test_rst_redirect();
    test_enable();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
